// File: rtl/riscv_lsu_pkg.sv
// Shared types and constants for the RISC-V load/store unit.
// Size codes follow the RISC-V load/store funct3 encoding.
package riscv_lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/riscv_lsu_fmt.sv
// Lane formatting for the LSU: byte enables and store replication on the request side,
// lane select with sign/zero extension on the response side. Unknown sizes behave as W.
module riscv_lsu_fmt
  import riscv_lsu_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wd,
  input  logic [31:0] rd_word,
  output logic [3:0]  be,
  output logic [31:0] wd_rep,
  output logic [31:0] rd_ext
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Select the addressed byte and half of the read word.
  always_comb begin
    byte_lane = rd_word[7:0];
    case (addr_lo)
      2'd0:    byte_lane = rd_word[7:0];
      2'd1:    byte_lane = rd_word[15:8];
      2'd2:    byte_lane = rd_word[23:16];
      2'd3:    byte_lane = rd_word[31:24];
      default: byte_lane = rd_word[7:0];
    endcase
    if (addr_lo[1]) begin
      half_lane = rd_word[31:16];
    end else begin
      half_lane = rd_word[15:0];
    end
  end

  // Per-size enables, store replication and load extension.
  always_comb begin
    be     = 4'b1111;
    wd_rep = wd;
    rd_ext = rd_word;
    case (size)
      LDST_B: begin
        be     = 4'b0001 << addr_lo;
        wd_rep = {4{wd[7:0]}};
        rd_ext = {{24{byte_lane[7]}}, byte_lane};
      end
      LDST_BU: begin
        be     = 4'b0001 << addr_lo;
        wd_rep = {4{wd[7:0]}};
        rd_ext = {24'h000000, byte_lane};
      end
      LDST_H: begin
        be     = 4'b0011 << addr_lo;
        wd_rep = {2{wd[15:0]}};
        rd_ext = {{16{half_lane[15]}}, half_lane};
      end
      LDST_HU: begin
        be     = 4'b0011 << addr_lo;
        wd_rep = {2{wd[15:0]}};
        rd_ext = {16'h0000, half_lane};
      end
      default: begin
        be     = 4'b1111;
        wd_rep = wd;
        rd_ext = rd_word;
      end
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: turns core memory requests into word-addressed bus accesses with
// byte enables, formats load data, and stalls the core until the access completes or times out.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        misaligned_o,
  output logic        fault_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  lsu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q, fault_q;
  logic [2:0]       size_q;
  logic [31:0]      addr_q, wd_q, rd_q;
  logic [3:0]       be_q;
  logic             misaligned, accept, timeout_hit;
  logic [2:0]       fmt_size;
  logic [1:0]       fmt_addr;
  logic [3:0]       fmt_be;
  logic [31:0]      fmt_wd, fmt_rd;

  // Alignment check on the live request; unknown sizes are treated as W.
  always_comb begin
    misaligned = 1'b0;
    case (core_size_i)
      LDST_B, LDST_BU: misaligned = 1'b0;
      LDST_H, LDST_HU: misaligned = core_addr_i[0];
      default:         misaligned = |core_addr_i[1:0];
    endcase
    misaligned = misaligned & core_req_i;
  end

  assign misaligned_o = misaligned;
  assign accept       = core_req_i & ~misaligned;
  assign core_stall_o = accept & (state_q != RESP);
  assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_LAST);

  // One formatter serves the request in IDLE and the response in WAIT.
  assign fmt_size = (state_q == WAIT) ? size_q : core_size_i;
  assign fmt_addr = (state_q == WAIT) ? addr_q[1:0] : core_addr_i[1:0];

  riscv_lsu_fmt u_fmt (
    .size    (fmt_size),
    .addr_lo (fmt_addr),
    .wd      (core_wd_i),
    .rd_word (mem_rd_i),
    .be      (fmt_be),
    .wd_rep  (fmt_wd),
    .rd_ext  (fmt_rd)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; bus ready wins over timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (mem_ready_i || timeout_hit) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, wait counter and response capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= 3'd0;
      addr_q  <= 32'h0000_0000;
      be_q    <= 4'b0000;
      wd_q    <= 32'h0000_0000;
      rd_q    <= 32'h0000_0000;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (accept) begin
            we_q   <= core_we_i;
            size_q <= core_size_i;
            addr_q <= core_addr_i;
            be_q   <= fmt_be;
            wd_q   <= fmt_wd;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (mem_ready_i) begin
            rd_q    <= fmt_rd;
            fault_q <= 1'b0;
          end else if (timeout_hit) begin
            rd_q    <= 32'h0000_0000;
            fault_q <= 1'b1;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  // Outputs decoded from state; everything is zero outside its owning state.
  always_comb begin
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_be_o   = 4'b0000;
    mem_addr_o = 32'h0000_0000;
    mem_wd_o   = 32'h0000_0000;
    core_rd_o  = 32'h0000_0000;
    fault_o    = 1'b0;
    case (state_q)
      WAIT: begin
        mem_req_o  = 1'b1;
        mem_we_o   = we_q;
        mem_be_o   = be_q;
        mem_addr_o = {addr_q[31:2], 2'b00};
        mem_wd_o   = wd_q;
      end
      RESP: begin
        core_rd_o = rd_q;
        fault_o   = fault_q;
      end
      default: begin
        mem_req_o = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load/store unit between riscv_core's data-memory port and the data RAM/peripheral bus.
- Takes the core's mem request (req/we/size/addr/wd) and drives a word-addressed bus with byte enables.
- Formats load data: lane select plus sign/zero extension.
- Generates the core's stall_i and holds it until the bus transaction completes or times out.

Parameters:
- TIMEOUT_CYCLES, 16, cycles spent in WAIT without mem_ready_i before the access is aborted with a fault; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- core_req_i  in  1  core requests a memory access
- core_we_i  in  1  1 = store, 0 = load
- core_size_i  in  3  RISC-V funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU
- core_addr_i  in  32  byte address
- core_wd_i  in  32  store data, right-aligned
- core_rd_o  out  32  formatted load data
- core_stall_o  out  1  to riscv_core stall_i
- misaligned_o  out  1  request is misaligned for its size (combinational)
- fault_o  out  1  bus timeout, valid in the RESP cycle
- mem_req_o  out  1  bus request
- mem_we_o  out  1  bus write
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  word address {addr[31:2], 2'b00}
- mem_wd_o  out  32  lane-replicated store data
- mem_rd_i  in  32  bus read word
- mem_ready_i  in  1  bus completes the access this cycle

Behaviour:
- Reset (rst_ni low, async): state IDLE, timeout counter 0; all outputs 0.
- misaligned_o = core_req_i & ((H|HU & addr[0]) | (W & addr[1:0] != 0)). A misaligned request never leaves IDLE, never stalls, and never drives mem_req_o.
- Sizes 3, 6, 7 are treated as W.
- IDLE:
  - If core_req_i & ~misaligned_o: latch we, size, addr, be, wd into registers; go to WAIT.
  - core_stall_o = 1 in this cycle.
- WAIT:
  - mem_req_o = 1; mem_we/be/addr/wd driven from the latched registers, stable until exit.
  - Counter increments each cycle.
  - On mem_ready_i: latch formatted mem_rd_i into rd_q, clear fault_q, go to RESP.
  - Else, if TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1: set fault_q, rd_q = 0, go to RESP.
  - mem_ready_i has priority over the timeout in the same cycle.
- RESP:
  - mem_req_o = 0, core_stall_o = 0, core_rd_o = rd_q, fault_o = fault_q.
  - Next state IDLE; counter cleared.
- core_stall_o = core_req_i & ~misaligned_o & (state != RESP).
- core_rd_o = 0 outside RESP.
- Minimum load/store latency is 3 cycles: IDLE, WAIT with ready, RESP. The core advances PC and writes the GPR in the RESP cycle.
- If core_req_i drops during WAIT (e.g. trap): the bus transaction still completes or times out, and RESP occurs. Result is ignored by the core; stall is already low.
- Byte enables:
  - B/BU: 0001 << addr[1:0].
  - H/HU: 0011 << addr[1:0].
  - W: 1111.
  - Loads drive the same be pattern.
- Store data:
  - B: {4{wd[7:0]}}.
  - H: {2{wd[15:0]}}.
  - W: wd.
- Load format, using the latched addr[1:0]:
  - B: sign-extend byte lane addr[1:0].
  - BU: zero-extend that lane.
  - H: sign-extend half lane addr[1].
  - HU: zero-extend that lane.
  - W: full word.
- Reset mid-WAIT: mem_req_o drops asynchronously; no response is delivered.
- Width rules: counter is $clog2(TIMEOUT_CYCLES+1) bits; it is compared only in WAIT.

Decomposition:
- riscv_lsu_pkg holds:
  - Size localparams LDST_B=0, LDST_H=1, LDST_W=2, LDST_BU=4, LDST_HU=5.
  - typedef enum lsu_state_t {IDLE, WAIT, RESP}.
- One combinational sub-module, riscv_lsu_fmt: (size, addr[1:0], wd, rd_word) -> (be, wd_rep, rd_ext). It is shared by the request and response paths.

Test Plan:
- LW at addr 0x100, mem_ready_i in first WAIT cycle, mem_rd_i=0xDEADBEEF:
  - mem_addr_o=0x100, be=1111.
  - core_stall_o high for 2 cycles.
  - RESP core_rd_o=0xDEADBEEF, fault_o=0.
- LB addr 0x203 with mem_rd_i=0x80123456 -> be=1000, core_rd_o=0xFFFFFF80.
- LBU same stimulus -> core_rd_o=0x00000080.
- SH addr 0x302, wd=0x0000ABCD -> mem_we_o=1, be=1100, mem_wd_o=0xABCDABCD, mem_addr_o=0x300.
- LW addr 0x102 -> misaligned_o=1, core_stall_o=0, mem_req_o never asserted.
- LW with mem_ready_i held low, TIMEOUT_CYCLES=16:
  - 16 WAIT cycles, then RESP with fault_o=1 and core_rd_o=0.
  - mem_ready_i arriving on cycle 16 gives fault_o=0 instead.
- rst_ni pulsed low during WAIT -> mem_req_o=0 immediately, state IDLE, next request served normally.
